csr_tohost_unit: RTL and testbench
==================================

// Module: csr_tohost_unit
// PURPOSE
// - CPU-side CSR unit that executes Zicsr instructions: CSRRW/RS/RC and CSRRWI/RSI/RCI.
// - Owns the tohost register (CSR 0x51E). Simulation benches watch tohost[0] for test completion
//   and tohost[31:1] for the failing test number.
// - Provides read-only cycle and instret counters (0xC00/0xC80, 0xC02/0xC82).
// - Sits in the execute stage: decode supplies the instruction fields, writeback receives csr_rdata.
// PARAMETERS
// - TOHOST_ADDR  12'h51E  address of the tohost CSR
// - CNT_WIDTH    64       width of the cycle/instret counters; must be 33..64
// PORTS
// - clk          in   1   CPU clock; all state updates on rising edge
// - rst_n        in   1   asynchronous, active-low reset
// - stall        in   1   pipeline hold; freezes CSR writes and output registers (counters keep running)
// - csr_valid    in   1   execute-stage instruction is a CSR op
// - csr_funct3   in   3   001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
// - csr_addr     in   12  CSR address
// - rs1_idx      in   5   rs1 field; this is the zimm value for the I-forms
// - rs1_data     in   32  forwarded rs1 value
// - retire       in   1   one instruction retired this cycle
// - csr_rdata    out  32  old CSR value for rd; registered, valid one cycle after accept
// - csr_rvalid   out  1   csr_rdata valid pulse
// - csr_illegal  out  1   registered pulse: unknown address, or write to a read-only CSR
// - tohost       out  32  current tohost register value
// BEHAVIOUR
// - Reset (async, rst_n=0): tohost, cycle, instret, csr_rdata, csr_rvalid and csr_illegal all go to 0
//   immediately. Counting resumes on the first rising edge after rst_n=1.
//   - Reset mid-operation discards any accepted-but-unreported access. No pulse is emitted.
// - Accept: an access is accepted on a rising edge when csr_valid=1 and stall=0.
//   - Write operand src = rs1_data for funct3[2]=0; src = {27'b0, rs1_idx} for funct3[2]=1.
//   - RW/RWI: new = src; write always occurs.
//   - RS/RSI: new = old | src.  RC/RCI: new = old & ~src.
//   - RS/RC-type writes are suppressed when rs1_idx == 0. Such accesses are pure reads and are legal
//     on read-only CSRs.
// - Address map (read value):
//   - TOHOST_ADDR: tohost; read/write.
//   - 0xC00: cycle[31:0]; 0xC80: cycle[CNT_WIDTH-1:32], zero-extended to 32 bits.
//   - 0xC02: instret[31:0]; 0xC82: instret[CNT_WIDTH-1:32], zero-extended to 32 bits.
//   - Counters are read-only.
//   - Any other address reads 0 and is illegal.
// - Latency: csr_rdata, csr_rvalid and csr_illegal are registered and appear the cycle after accept.
//   - csr_rvalid is a 1-cycle pulse, also asserted when csr_illegal=1; csr_rdata is then 0.
//   - The tohost write is visible on the tohost output the cycle after accept.
//   - Read returns the pre-write value (atomic read-modify-write).
// - Illegal write (a write that is not suppressed, to a counter): no state change, csr_illegal pulses.
// - Back-to-back accesses to tohost: the second access reads the value written by the first.
// - Under stall=1:
//   - No accept occurs.
//   - csr_rdata, csr_rvalid and csr_illegal hold their values.
//   - cycle still increments every cycle; instret increments only on retire=1.
// - Counters wrap modulo 2^CNT_WIDTH with no saturation or flag.
//   - The 32-bit low half carries into the high half in the same cycle.
// - Simultaneous retire and CSR read of instret: the read returns the value before this cycle's increment.
// - tohost changes only via a CSR write and holds indefinitely otherwise.
// TESTING
// - Reset: hold rst_n=0 for 5 cycles, then release.
//   -> tohost=0, csr_rvalid=0; a read of 0xC00 issued 3 cycles after release returns 3.
// - csrwi 0x51E, 1: funct3=101, rs1_idx=1.
//   -> next cycle tohost=32'h1, csr_rdata=0, csr_rvalid=1 for exactly one cycle.
// - csrw 0x51E with rs1_data=32'h0000_000B, then csrrs with rs1_data=32'h4, then csrrc with rs1_idx=0.
//   -> tohost goes 0xB, then 0xF, then remains 0xF; csr_rdata reads 0, then 0xB, then 0xF.
// - csrw 0xC00 with rs1_idx=5 -> csr_illegal=1, counter unchanged; csrrs 0xC00 with rs1_idx=0 -> legal.
//   Access to 0x7C0 -> csr_illegal=1, csr_rdata=0.
// - Force cycle low half to 32'hFFFF_FFFF and advance 1 cycle -> 0xC00 reads 0, 0xC80 reads 1.
//   retire=1 for 10 cycles -> 0xC02 reads 10.
// - stall=1 while csr_valid=1 for 4 cycles -> no tohost change, no csr_rvalid pulse.
//   Release stall -> the access completes once. Assert rst_n=0 mid-access -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/csr_tohost_unit.sv
// csr_tohost_unit: Zicsr execute-stage unit owning tohost plus read-only cycle/instret counters
module csr_tohost_unit #(
  parameter logic [11:0] TOHOST_ADDR = 12'h51E,
  parameter int          CNT_WIDTH   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        csr_valid,
  input  logic [2:0]  csr_funct3,
  input  logic [11:0] csr_addr,
  input  logic [4:0]  rs1_idx,
  input  logic [31:0] rs1_data,
  input  logic        retire,
  output logic [31:0] csr_rdata,
  output logic        csr_rvalid,
  output logic        csr_illegal,
  output logic [31:0] tohost
);
  logic [CNT_WIDTH-1:0] cycle, instret;
  logic [31:0] src, old, nxt;
  logic hit_th, hit_cnt, wr_en, ill;
  always_comb begin
    src     = csr_funct3[2] ? {27'b0, rs1_idx} : rs1_data;
    hit_th  = csr_addr == TOHOST_ADDR;
    hit_cnt = csr_addr inside {12'hC00, 12'hC80, 12'hC02, 12'hC82};
    old     = hit_th              ? tohost :
              csr_addr == 12'hC00 ? cycle[31:0] :
              csr_addr == 12'hC80 ? 32'(cycle >> 32) :
              csr_addr == 12'hC02 ? instret[31:0] :
              csr_addr == 12'hC82 ? 32'(instret >> 32) : 32'b0;
    // set/clear with a zero rs1 field never writes, so it is a legal read of a counter
    wr_en   = csr_funct3[1:0] == 2'b01 || rs1_idx != 5'd0;
    ill     = csr_funct3[1:0] == 2'b00 || !(hit_th || hit_cnt) || (hit_cnt && wr_en);
    nxt     = csr_funct3[1:0] == 2'b01 ? src :
              csr_funct3[1:0] == 2'b10 ? old | src : old & ~src;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle       <= '0;
      instret     <= '0;
      tohost      <= '0;
      csr_rdata   <= '0;
      csr_rvalid  <= 1'b0;
      csr_illegal <= 1'b0;
    end else begin
      cycle <= cycle + 1'b1;
      if (retire) instret <= instret + 1'b1;
      if (!stall) begin
        csr_rvalid  <= csr_valid;
        csr_illegal <= csr_valid && ill;
        csr_rdata   <= (csr_valid && !ill) ? old : 32'b0;
        if (csr_valid && !ill && hit_th && wr_en) tohost <= nxt;
      end
    end
  end
endmodule

// File: tb/tb_csr_tohost_unit.sv
// tb_csr_tohost_unit: scoreboard bench for csr_tohost_unit
module tb_csr_tohost_unit;
  logic clk = 1'b0, rst_n, stall, csr_valid, retire;
  logic [2:0] csr_funct3;
  logic [11:0] csr_addr;
  logic [4:0] rs1_idx;
  logic [31:0] rs1_data, csr_rdata, tohost;
  logic csr_rvalid, csr_illegal;
  logic lst = 1'b1;
  logic [63:0] ncyc;
  int total = 0, bad = 0;
  typedef struct {logic [31:0] d; logic il;} exp_t;
  exp_t q[$];
  exp_t e;

  csr_tohost_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .csr_valid(csr_valid), .csr_funct3(csr_funct3),
    .csr_addr(csr_addr), .rs1_idx(rs1_idx), .rs1_data(rs1_data), .retire(retire),
    .csr_rdata(csr_rdata), .csr_rvalid(csr_rvalid), .csr_illegal(csr_illegal), .tohost(tohost)
  );

  always #5 clk = ~clk;
  always @(posedge clk) lst <= stall;
  always @(posedge clk or negedge rst_n) ncyc <= !rst_n ? 64'd0 : ncyc + 64'd1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic op(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                    input logic [31:0] d, input logic [31:0] ed, input logic ei);
    csr_valid = 1'b1; csr_funct3 = f3; csr_addr = a; rs1_idx = idx; rs1_data = d;
    q.push_back('{ed, ei});
    @(negedge clk);
  endtask

  task automatic idle();
    csr_valid = 1'b0;
    @(negedge clk);
  endtask

  // a fresh result is one whose producing edge was not stalled
  always @(negedge clk) begin
    if (rst_n && csr_rvalid && !lst) begin
      if (q.size() == 0) chk("unexpected_rvalid", 1, 0);
      else begin
        e = q.pop_front();
        chk("rdata", csr_rdata, e.d);
        chk("illegal", csr_illegal, e.il);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 0; stall = 0; csr_valid = 0; csr_funct3 = 0; csr_addr = 0;
    rs1_idx = 0; rs1_data = 0; retire = 0;
    repeat (5) @(negedge clk);
    chk("rst_tohost", tohost, 0);
    chk("rst_rvalid", csr_rvalid, 0);
    rst_n = 1;
    repeat (3) @(negedge clk);
    op(3'b010, 12'hC00, 0, 0, 32'd3, 0);
    idle();
    retire = 1;
    repeat (10) @(negedge clk);
    retire = 0;
    op(3'b010, 12'hC02, 0, 0, 32'd10, 0);
    retire = 1;
    op(3'b010, 12'hC02, 0, 0, 32'd10, 0);
    retire = 0;
    op(3'b010, 12'hC02, 0, 0, 32'd11, 0);
    op(3'b010, 12'hC82, 0, 0, 32'd0, 0);
    idle();
    op(3'b101, 12'h51E, 1, 0, 32'd0, 0);
    chk("csrwi_tohost", tohost, 32'h1);
    idle();
    chk("pulse_once", csr_rvalid, 0);
    op(3'b001, 12'h51E, 0, 32'hB, 32'h1, 0);
    chk("csrw_tohost", tohost, 32'hB);
    op(3'b010, 12'h51E, 2, 32'h4, 32'hB, 0);
    chk("csrrs_tohost", tohost, 32'hF);
    op(3'b011, 12'h51E, 0, 32'hFFFF_FFFF, 32'hF, 0);
    chk("csrrc0_tohost", tohost, 32'hF);
    op(3'b111, 12'h51E, 3, 0, 32'hF, 0);
    chk("csrrci_tohost", tohost, 32'hC);
    idle();
    op(3'b001, 12'hC02, 5, 32'h123, 32'd0, 1);
    op(3'b101, 12'hC00, 5, 0, 32'd0, 1);
    op(3'b010, 12'hC00, 0, 0, ncyc[31:0], 0);
    op(3'b010, 12'hC02, 0, 0, 32'd11, 0);
    op(3'b010, 12'h7C0, 0, 0, 32'd0, 1);
    idle();
    force dut.cycle = 64'hFFFF_FFFF;
    #1 release dut.cycle;
    @(negedge clk);
    op(3'b010, 12'hC00, 0, 0, 32'd0, 0);
    op(3'b010, 12'hC80, 0, 0, 32'd1, 0);
    idle();
    op(3'b001, 12'h51E, 0, 32'hAA, 32'hC, 0);
    csr_valid = 0; stall = 1;
    @(negedge clk);
    chk("hold_rvalid", csr_rvalid, 1);
    chk("hold_rdata", csr_rdata, 32'hC);
    stall = 0;
    @(negedge clk);
    chk("hold_release", csr_rvalid, 0);
    chk("hold_tohost", tohost, 32'hAA);
    stall = 1; csr_valid = 1; csr_funct3 = 3'b001; csr_addr = 12'h51E; rs1_idx = 0; rs1_data = 32'h55;
    q.push_back('{32'hAA, 1'b0});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_rvalid", csr_rvalid, 0);
      chk("stall_tohost", tohost, 32'hAA);
    end
    stall = 0;
    @(negedge clk);
    chk("unstall_tohost", tohost, 32'h55);
    csr_valid = 0;
    @(negedge clk);
    chk("unstall_once", csr_rvalid, 0);
    csr_valid = 1; rs1_data = 32'h77;
    @(posedge clk);
    #2;
    chk("mid_rvalid", csr_rvalid, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_rvalid", csr_rvalid, 0);
    chk("mid_rst_rdata", csr_rdata, 0);
    chk("mid_rst_illegal", csr_illegal, 0);
    chk("mid_rst_tohost", tohost, 0);
    q.delete();
    csr_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_tohost", tohost, 0);
    chk("post_rst_rvalid", csr_rvalid, 0);
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
